// File: rtl/mem_req_arbiter.sv
// Two-master (fetch, data) to one-slave SRAM-like arbiter with fixed data priority,
// grant hold until acceptance, and an in-order source-tag FIFO for response routing.
module mem_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [DEPTH-1:0] tags;

  logic gnt_i;
  logic gnt_d;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
  assign head  = tags[rptr];
  assign push  = s_req & s_addr_ok;
  assign pop   = s_data_ok & ~empty;

  // Grant selection: live priority arbitration in NONE, forced grant while holding.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    case (state)
      NONE: begin
        if (full) begin
          gnt_d = 1'b0;
        end else if (data_req) begin
          gnt_d = 1'b1;
        end else if (inst_req) begin
          gnt_i = 1'b1;
        end else begin
          gnt_i = 1'b0;
        end
      end
      HOLD_I:  gnt_i = 1'b1;
      HOLD_D:  gnt_d = 1'b1;
      default: gnt_i = 1'b0;
    endcase
  end

  // Slave request mux; fields read as zero when nobody holds the grant.
  always_comb begin
    s_req   = 1'b0;
    s_wr    = 1'b0;
    s_size  = 2'd0;
    s_addr  = 32'd0;
    s_wstrb = 4'd0;
    s_wdata = 32'd0;
    if (gnt_d) begin
      s_req   = data_req;
      s_wr    = data_wr;
      s_size  = data_size;
      s_addr  = data_addr;
      s_wstrb = data_wstrb;
      s_wdata = data_wdata;
    end else if (gnt_i) begin
      s_req   = inst_req;
      s_wr    = inst_wr;
      s_size  = inst_size;
      s_addr  = inst_addr;
      s_wstrb = inst_wstrb;
      s_wdata = inst_wdata;
    end else begin
      s_req   = 1'b0;
    end
  end

  assign inst_addr_ok = gnt_i & s_addr_ok;
  assign data_addr_ok = gnt_d & s_addr_ok;
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;

  // Grant state, source-tag FIFO and sticky spurious-response flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= NONE;
      count        <= CW'(0);
      wptr         <= PW'(0);
      rptr         <= PW'(0);
      tags         <= DEPTH'(0);
      err_spurious <= 1'b0;
    end else begin
      if (gnt_d & data_req & ~s_addr_ok) begin
        state <= HOLD_D;
      end else if (gnt_i & inst_req & ~s_addr_ok) begin
        state <= HOLD_I;
      end else begin
        state <= NONE;
      end

      if (push) begin
        tags[wptr] <= gnt_d;
        wptr       <= wptr + PW'(1);
      end else begin
        wptr       <= wptr;
      end

      if (pop) begin
        rptr <= rptr + PW'(1);
      end else begin
        rptr <= rptr;
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A response with nothing outstanding is dropped and latched as an error.
      if (s_data_ok & empty) begin
        err_spurious <= 1'b1;
      end else begin
        err_spurious <= err_spurious;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a cycle table for arbitration, hold and
// routing, then hand-written sequences for full FIFO, wrap, spurious and reset.
module tb_mem_req_arbiter;

  localparam logic [31:0] I_ADDR = 32'hA000_0004;
  localparam logic [31:0] D_ADDR = 32'hD000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, s_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, s_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, err_spurious;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ireq;
    logic        dreq;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        exp_sreq;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_iaok;
    logic        exp_daok;
    logic        exp_idok;
    logic        exp_ddok;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the falling edge; outputs settle 2 time units later.
  task automatic drive(input logic i, input logic d, input logic a, input logic k,
                       input logic [31:0] rd);
    @(negedge clk);
    inst_req  = i;
    data_req  = d;
    s_addr_ok = a;
    s_data_ok = k;
    s_rdata   = rd;
    #2;
  endtask

  task automatic chk_ok(input string name, input logic sr, input logic ia, input logic da,
                        input logic id, input logic dd);
    chk({name, ".s_req"}, {31'd0, s_req}, {31'd0, sr});
    chk({name, ".inst_addr_ok"}, {31'd0, inst_addr_ok}, {31'd0, ia});
    chk({name, ".data_addr_ok"}, {31'd0, data_addr_ok}, {31'd0, da});
    chk({name, ".inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, id});
    chk({name, ".data_data_ok"}, {31'd0, data_data_ok}, {31'd0, dd});
  endtask

  initial begin
    // simultaneous requests, then routing of two responses
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, D_ADDR, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0};
    // inst held three cycles while data rises, data granted after acceptance
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, D_ADDR, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1};
    // held data master drops its request: no push, back to NONE
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, D_ADDR, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, I_ADDR, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = I_ADDR;
    inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b1; data_size = 2'd2; data_addr = D_ADDR;
    data_wstrb = 4'hF; data_wdata = 32'h55AA_55AA;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #2;
    chk("reset.err_spurious", {31'd0, err_spurious}, 32'd0);
    chk_ok("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 16; n++) begin
      drive(vecs[n].ireq, vecs[n].dreq, vecs[n].aok, vecs[n].dok, vecs[n].rdata);
      chk_ok($sformatf("vec%0d", n), vecs[n].exp_sreq, vecs[n].exp_iaok, vecs[n].exp_daok,
             vecs[n].exp_idok, vecs[n].exp_ddok);
      if (vecs[n].chk_addr) begin
        chk($sformatf("vec%0d.s_addr", n), s_addr, vecs[n].exp_addr);
        chk($sformatf("vec%0d.s_wr", n), {31'd0, s_wr},
            {31'd0, vecs[n].exp_sreq & (vecs[n].exp_addr == D_ADDR)});
        chk($sformatf("vec%0d.s_wdata", n), s_wdata,
            (vecs[n].exp_addr == D_ADDR) ? 32'h55AA_55AA : 32'h0);
      end
      chk($sformatf("vec%0d.inst_rdata", n), inst_rdata, vecs[n].rdata);
      chk($sformatf("vec%0d.data_rdata", n), data_rdata, vecs[n].rdata);
    end
    chk("table.err_spurious", {31'd0, err_spurious}, 32'd0);

    // Fill the FIFO with tags 1,0,1,0; a fifth request must not be granted.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); chk_ok("fill1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); chk_ok("fill2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); chk_ok("fill3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); chk_ok("fill4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); chk_ok("full", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.s_addr", s_addr, 32'h0);
    // Pop while full: still no grant this cycle, grant resumes next cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hA1); chk_ok("full_pop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hA2); chk_ok("regrant", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    // Hold data across a pop, then accept and pop in the same cycle past the wrap.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hA3); chk_ok("wrap1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hA4); chk_ok("wrap2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap2.s_addr", s_addr, D_ADDR);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA5); chk_ok("wrap3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA6); chk_ok("wrap4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Spurious response with the FIFO empty.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD); chk_ok("spur", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("spur.err_set", {31'd0, err_spurious}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("spur.err_sticky", {31'd0, err_spurious}, 32'd1);

    // Reset with two outstanding requests and an inst grant held.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst.held_addr", s_addr, I_ADDR);
    #1 reset = 1'b1;
    #1;
    chk("rst.err_async", {31'd0, err_spurious}, 32'd0);
    chk("rst.grant_async", s_addr, D_ADDR);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_6666);
    chk_ok("rst.late_resp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst.late_err", {31'd0, err_spurious}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
